vip_frame_stream_gen: RTL and testbench
=======================================

Name: vip_frame_stream_gen

Overview:
- Transmit side of the per_frame_vsync/href/hsync + 8-bit Y pixel video interface consumed by the ISP window/filter blocks.
- Generates raster timing from programmable porch/sync parameters.
- Pulls pixels from an upstream valid/ready stream with a start-of-frame marker.
- Fills on underflow and re-aligns to the next SOF on framing error.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- FILL_VAL, 8'h00, pixel emitted on underflow or while not aligned
- CNT_W, 12, width of h/v counters (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- enable  in  1  run request
- clr_status  in  1  clears sticky flags
- s_valid  in  1  upstream pixel valid
- s_data  in  8  upstream pixel
- s_sof  in  1  marks first pixel of a frame
- s_ready  out  1  pixel accepted this cycle when s_valid&&s_ready
- per_frame_vsync  out  1  active-high vsync
- per_frame_hsync  out  1  active-high hsync
- per_frame_href  out  1  high during active pixels
- per_img_Y  out  8  pixel, valid when href
- frame_done  out  1  one-cycle pulse after last active pixel of a frame
- underflow  out  1  sticky: active pixel had no valid input
- frame_err  out  1  sticky: SOF missing at frame start or present mid-frame

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). On rst: counters=0, state=IDLE, all outputs 0.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps, incrementing v_cnt. v_cnt wraps at V_TOTAL-1.
- Timing decode from (h_cnt,v_cnt):
  - active: h<H_ACTIVE && v<V_ACTIVE
  - hsync: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync: V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines)
- Latency: all video outputs registered. The sync/href/pixel triple is aligned 1 clk after the counter state that produced it. s_ready is combinational from current counters/state.
- States:
  - IDLE: counters held 0; s_ready=0; outputs 0. enable=1 -> SEEK.
  - SEEK: counters run; video emits FILL_VAL with normal timing.
    - s_ready=1 for beats with s_sof=0 (discarded).
    - At h=0,v=0: if s_valid&&s_sof, consume it as pixel 0 and go to RUN; else set frame_err and stay in SEEK.
    - While not at h=0,v=0, a beat with s_sof=1 is held (s_ready=0).
  - RUN: s_ready=1 only on active cycles.
    - s_valid=0 on an active cycle -> emit FILL_VAL, set underflow; counters never stall.
    - s_sof=1 on an active cycle other than h=0,v=0 -> beat not consumed, FILL_VAL emitted, frame_err set, go to SEEK.
    - At h=0,v=0 with s_valid and s_sof=0 -> frame_err, go to SEEK.
- enable deassert: finish the current frame. At wrap of the last line go to IDLE, counters reset to 0.
- frame_done: pulses the cycle after h=H_ACTIVE-1, v=V_ACTIVE-1 is output, in any non-IDLE state.
- Sticky flags clear on clr_status. If set and clear coincide, set wins.
- rst mid-frame: immediate return to IDLE; no partial-line completion.

Optional Feature:
- Macro VIP_FRAME_GEN_PATTERN_EN.
- Defined: adds input pattern_sel (1 bit). When pattern_sel=1 in any non-IDLE state:
  - per_img_Y = h_cnt[7:0] ^ v_cnt[7:0] on active cycles
  - s_ready=0 and the stream is ignored
  - no underflow or frame_err updates
  - pattern_sel is sampled at the h=0,v=0 cycle only.
- Undefined: no port and no logic; behaviour as above.

Decomposition:
- Package vip_pkg holds:
  - state enum (IDLE, SEEK, RUN)
  - timing-region helper constants H_TOTAL/V_TOTAL computed from parameters
  - FILL default
- One natural sub-module: vip_timing_counter (h/v counters plus active/hsync/vsync decode), reusable by other generators.

Test Plan:
Use H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1.
1. Ideal stream of 32 ramp bytes 0..31, sof on the first -> href high 8 clks per line on 4 lines, per_img_Y 0..31 in order, hsync 2 clks starting at h=10, vsync one line at v=5, frame_done once, flags 0.
2. s_valid dropped for pixel 5 of line 1 -> that output = FILL_VAL, underflow=1, later pixels shifted by one, no timing slip.
3. No sof on the first beat after enable -> frame_err=1, SEEK discards beats until sof, then the next frame starts at h=0,v=0 with the sof pixel.
4. sof presented at pixel 20 of a frame -> frame_err=1, FILL_VAL for the remaining pixels, sof pixel emitted as pixel 0 of the next frame.
5. enable dropped at v=1 -> the frame completes with timing intact, then IDLE with all outputs 0 and s_ready=0.
6. rst asserted mid-line, then clr_status with a flag set -> all outputs 0 the next cycle; a coincident underflow and clr_status leaves underflow=1.

Source files
------------

// File: rtl/vip_frame_stream_gen_pkg.sv
// Shared types and default timing for the video frame stream generator.
// Package vip_pkg: FSM state enum, default raster parameters and the
// helper that turns porch/sync/active widths into a total period.
package vip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_RUN  = 2'd2
  } vip_state_e;

  // Sum of active, front porch, sync and back porch gives one full period.
  function automatic int calc_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 12;

  localparam int H_TOTAL_DEF = calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL_DEF = calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  localparam logic [7:0] FILL_DEF = 8'h00;

endpackage

// File: rtl/vip_frame_stream_gen_if.sv
// Upstream pixel stream: valid/ready handshake with a start-of-frame marker.
// master = pixel source, slave = the frame generator consuming pixels.
interface vip_stream_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_sof;
  logic       s_ready;

  modport master (output s_valid, output s_data, output s_sof, input s_ready);
  modport slave  (input s_valid, input s_data, input s_sof, output s_ready);
endinterface

// File: rtl/vip_frame_stream_gen_timing.sv
// Raster timing counter: h/v counters plus active/hsync/vsync decode.
// Counters are held at zero while run_i is low; decode is combinational
// from the current counter values so callers can register it as needed.
module vip_timing_counter
  import vip_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             origin_o,
  output logic             frame_end_o
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;

  // Advance h every clock, v on each line wrap; both wrap at their totals.
  always_ff @(posedge clk) begin
    if (rst || !run_i) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == H_LAST) begin
      h_q <= '0;
      if (v_q == V_LAST) begin
        v_q <= '0;
      end else begin
        v_q <= v_q + ONE_C;
      end
    end else begin
      h_q <= h_q + ONE_C;
      v_q <= v_q;
    end
  end

  assign h_cnt_o     = h_q;
  assign v_cnt_o     = v_q;
  assign active_o    = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hsync_o     = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vsync_o     = (v_q >= VS_BEG) && (v_q < VS_END);
  assign origin_o    = (h_q == '0) && (v_q == '0);
  assign frame_end_o = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vip_frame_stream_gen.sv
// Video frame stream generator: produces vsync/hsync/href + 8-bit Y from an
// upstream valid/ready pixel stream, filling on underflow and realigning to
// the next start-of-frame after a framing error.
// Optional build macro VIP_FRAME_GEN_PATTERN_EN adds pattern_sel, which
// replaces the stream with an h^v test pattern for whole frames.
module vip_frame_stream_gen
  import vip_pkg::*;
#(
  parameter int         H_ACTIVE = DEF_H_ACTIVE,
  parameter int         H_FP     = DEF_H_FP,
  parameter int         H_SYNC   = DEF_H_SYNC,
  parameter int         H_BP     = DEF_H_BP,
  parameter int         V_ACTIVE = DEF_V_ACTIVE,
  parameter int         V_FP     = DEF_V_FP,
  parameter int         V_SYNC   = DEF_V_SYNC,
  parameter int         V_BP     = DEF_V_BP,
  parameter logic [7:0] FILL_VAL = FILL_DEF,
  parameter int         CNT_W    = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clr_status,
`ifdef VIP_FRAME_GEN_PATTERN_EN
  input  logic        pattern_sel,
`endif
  vip_stream_if.slave s_if,
  output logic        per_frame_vsync,
  output logic        per_frame_hsync,
  output logic        per_frame_href,
  output logic [7:0]  per_img_Y,
  output logic        frame_done,
  output logic        underflow,
  output logic        frame_err
);

  localparam logic [CNT_W-1:0] H_LAST_PX = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST_PX = CNT_W'(V_ACTIVE - 1);

  vip_state_e       state_q, state_d;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active_s, hsync_s, vsync_s, origin_s, frame_end_s;
  logic             ready_s, set_uf_s, set_fe_s;
  logic [7:0]       pix_s;
  logic             vsync_q, hsync_q, href_q, last_px_q, frame_done_q;
  logic             underflow_q, frame_err_q;
  logic [7:0]       y_q;

  vip_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W(CNT_W)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .run_i      (state_q != ST_IDLE),
    .h_cnt_o    (h_cnt),
    .v_cnt_o    (v_cnt),
    .active_o   (active_s),
    .hsync_o    (hsync_s),
    .vsync_o    (vsync_s),
    .origin_o   (origin_s),
    .frame_end_o(frame_end_s)
  );

`ifdef VIP_FRAME_GEN_PATTERN_EN
  logic pattern_q;
  logic pat_eff_s;
  // Pattern choice is taken at the frame origin and held for the whole frame.
  assign pat_eff_s = origin_s ? pattern_sel : pattern_q;
`endif

  // Next state, stream acceptance, pixel selection and flag set requests.
  always_comb begin
    state_d  = state_q;
    ready_s  = 1'b0;
    pix_s    = FILL_VAL;
    set_uf_s = 1'b0;
    set_fe_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SEEK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEEK: begin
        if (origin_s) begin
          // Frame start: only an SOF beat lets us lock on.
          ready_s = 1'b1;
          if (s_if.s_valid && s_if.s_sof) begin
            pix_s   = s_if.s_data;
            state_d = ST_RUN;
          end else begin
            set_fe_s = 1'b1;
          end
        end else begin
          // Discard stale beats, but hold an SOF for the next origin.
          ready_s = !s_if.s_sof;
        end
      end
      ST_RUN: begin
        if (active_s) begin
          if (s_if.s_sof && !origin_s) begin
            // Early SOF belongs to the next frame: leave it queued.
            set_fe_s = 1'b1;
            state_d  = ST_SEEK;
          end else begin
            ready_s = 1'b1;
            if (!s_if.s_valid) begin
              set_uf_s = 1'b1;
            end else if (origin_s && !s_if.s_sof) begin
              set_fe_s = 1'b1;
              state_d  = ST_SEEK;
            end else begin
              pix_s = s_if.s_data;
            end
          end
        end else begin
          ready_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef VIP_FRAME_GEN_PATTERN_EN
    if ((state_q != ST_IDLE) && pat_eff_s) begin
      ready_s  = 1'b0;
      set_uf_s = 1'b0;
      set_fe_s = 1'b0;
      state_d  = state_q;
      pix_s    = h_cnt[7:0] ^ v_cnt[7:0];
    end else begin
      pix_s = pix_s;
    end
`endif
    // A run request that went away ends the stream at the frame boundary.
    if ((state_q != ST_IDLE) && frame_end_s && !enable) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  assign s_if.s_ready = ready_s;

  // State, registered video outputs, frame_done pipeline and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      href_q       <= 1'b0;
      y_q          <= 8'h00;
      last_px_q    <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        vsync_q   <= 1'b0;
        hsync_q   <= 1'b0;
        href_q    <= 1'b0;
        y_q       <= 8'h00;
        last_px_q <= 1'b0;
      end else begin
        vsync_q   <= vsync_s;
        hsync_q   <= hsync_s;
        href_q    <= active_s;
        y_q       <= active_s ? pix_s : 8'h00;
        last_px_q <= (h_cnt == H_LAST_PX) && (v_cnt == V_LAST_PX);
      end
      frame_done_q <= last_px_q;
      underflow_q  <= set_uf_s | (underflow_q & ~clr_status);
      frame_err_q  <= set_fe_s | (frame_err_q & ~clr_status);
    end
  end

`ifdef VIP_FRAME_GEN_PATTERN_EN
  // Latch the pattern choice at each frame origin; clear when idle.
  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_IDLE)) begin
      pattern_q <= 1'b0;
    end else if (origin_s) begin
      pattern_q <= pattern_sel;
    end else begin
      pattern_q <= pattern_q;
    end
  end
`endif

  assign per_frame_vsync = vsync_q;
  assign per_frame_hsync = hsync_q;
  assign per_frame_href  = href_q;
  assign per_img_Y       = y_q;
  assign frame_done      = frame_done_q;
  assign underflow       = underflow_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_vip_frame_stream_gen.sv
// Scoreboard bench for vip_frame_stream_gen with a small 14x7 raster.
module tb_vip_frame_stream_gen;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       gap;
  } beat_t;

  logic clk = 1'b0;
  logic rst, enable, clr_status;
  logic vsync, hsync, href, fdone, uf, fe;
  logic [7:0] y;
`ifdef VIP_FRAME_GEN_PATTERN_EN
  logic pattern_sel = 1'b0;
`endif

  beat_t      src_q[$];
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int pix_no = 0;

  vip_stream_if sif();

  vip_frame_stream_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FILL_VAL(8'h00), .CNT_W(12)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .clr_status     (clr_status),
`ifdef VIP_FRAME_GEN_PATTERN_EN
    .pattern_sel    (pattern_sel),
`endif
    .s_if           (sif),
    .per_frame_vsync(vsync),
    .per_frame_hsync(hsync),
    .per_frame_href (href),
    .per_img_Y      (y),
    .frame_done     (fdone),
    .underflow      (uf),
    .frame_err      (fe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Source: presents the queue head each cycle, pops on acceptance (gap = one idle active slot).
  initial begin
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;
    sif.s_sof   = 1'b0;
    forever begin
      @(negedge clk);
      if (src_q.size() > 0) begin
        sif.s_valid = !src_q[0].gap;
        sif.s_data  = src_q[0].d;
        sif.s_sof   = src_q[0].sof;
      end else begin
        sif.s_valid = 1'b0;
        sif.s_data  = 8'h00;
        sif.s_sof   = 1'b0;
      end
      #1;
      if (src_q.size() > 0 && sif.s_ready === 1'b1 && (sif.s_valid || src_q[0].gap))
        void'(src_q.pop_front());
    end
  end

  // Monitor: every href cycle pops one expected pixel and compares.
  initial begin
    forever begin
      @(negedge clk);
      if (href === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("extra_pixel", 32'(y), 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk($sformatf("pixel%0d", pix_no), 32'(y), 32'(e));
        end
        pix_no++;
      end
    end
  end

  task automatic push_beat(input logic [7:0] d, input logic sof, input logic gap);
    beat_t b;
    b.d = d; b.sof = sof; b.gap = gap;
    src_q.push_back(b);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_href"}, 32'(href), 32'd0);
    chk({nm, "_hsync"}, 32'(hsync), 32'd0);
    chk({nm, "_vsync"}, 32'(vsync), 32'd0);
    chk({nm, "_y"}, 32'(y), 32'd0);
    chk({nm, "_fdone"}, 32'(fdone), 32'd0);
    chk({nm, "_ready"}, 32'(sif.s_ready), 32'd0);
  endtask

  // Run n frames, drop enable at v=1 of the last one, optionally pulse clr_status.
  task automatic run_frames(input int n, input int clr_idx, input logic exp_uf, input string nm);
    int drop_idx;
    drop_idx = (n - 1) * FT + HT;
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    for (int idx = 0; idx < n * FT; idx++) begin
      int c, h, v;
      @(negedge clk);
      c = idx % FT;
      h = c % HT;
      v = c / HT;
      chk({nm, "_href"}, 32'(href), 32'((h < 8) && (v < 4)));
      chk({nm, "_hsync"}, 32'(hsync), 32'((h >= 10) && (h < 12)));
      chk({nm, "_vsync"}, 32'(vsync), 32'(v == 5));
      chk({nm, "_fdone"}, 32'(fdone), 32'(c == 50));
      if (idx == drop_idx) enable = 1'b0;
      if (idx == clr_idx) clr_status = 1'b1;
      if (clr_idx >= 0 && idx == clr_idx + 1) begin
        clr_status = 1'b0;
        chk({nm, "_uf_after_clr"}, 32'(uf), 32'(exp_uf));
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_idle({nm, "_idle"});
    chk({nm, "_pixels_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_beats_left"}, 32'(src_q.size()), 32'd0);
  endtask

  task automatic clear_flags(input string nm);
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk({nm, "_uf_clr"}, 32'(uf), 32'd0);
    chk({nm, "_fe_clr"}, 32'(fe), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clr_status = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    chk("reset_uf", 32'(uf), 32'd0);
    chk("reset_fe", 32'(fe), 32'd0);
    rst = 1'b0;

    // 1: ideal ramp 0..31
    for (int i = 0; i < 32; i++) begin
      push_beat(8'(i), i == 0, 1'b0);
      exp_q.push_back(8'(i));
    end
    run_frames(1, -1, 1'b0, "t1");
    chk("t1_uf", 32'(uf), 32'd0);
    chk("t1_fe", 32'(fe), 32'd0);

    // 2: valid dropped at pixel 5 of line 1
    for (int i = 0; i < 13; i++) begin
      push_beat(8'(8'h40 + i), i == 0, 1'b0);
      exp_q.push_back(8'(8'h40 + i));
    end
    push_beat(8'h00, 1'b0, 1'b1);
    exp_q.push_back(8'h00);
    for (int i = 13; i < 31; i++) begin
      push_beat(8'(8'h40 + i), 1'b0, 1'b0);
      exp_q.push_back(8'(8'h40 + i));
    end
    run_frames(1, -1, 1'b0, "t2");
    chk("t2_uf", 32'(uf), 32'd1);
    chk("t2_fe", 32'(fe), 32'd0);
    clear_flags("t2");

    // 3: no sof at first beat, seek to the sof beat
    for (int i = 0; i < 3; i++) push_beat(8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 32; i++) begin
      push_beat(8'(8'h80 + i), i == 0, 1'b0);
      exp_q.push_back(8'(8'h80 + i));
    end
    run_frames(2, -1, 1'b0, "t3");
    chk("t3_fe", 32'(fe), 32'd1);
    chk("t3_uf", 32'(uf), 32'd0);
    clear_flags("t3");

    // 4: sof arrives at pixel 20
    for (int i = 0; i < 20; i++) begin
      push_beat(8'(8'hA0 + i), i == 0, 1'b0);
      exp_q.push_back(8'(8'hA0 + i));
    end
    for (int i = 0; i < 12; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 32; i++) begin
      push_beat(8'(8'hC0 + i), i == 0, 1'b0);
      exp_q.push_back(8'(8'hC0 + i));
    end
    run_frames(2, -1, 1'b0, "t4");
    chk("t4_fe", 32'(fe), 32'd1);
    chk("t4_uf", 32'(uf), 32'd0);
    clear_flags("t4");

    // 6a: rst mid-line
    for (int i = 0; i < 32; i++) begin
      push_beat(8'(8'h60 + i), i == 0, 1'b0);
      exp_q.push_back(8'(8'h60 + i));
    end
    @(negedge clk);
    enable = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("t6_rst");
    chk("t6_rst_uf", 32'(uf), 32'd0);
    chk("t6_rst_fe", 32'(fe), 32'd0);
    src_q.delete();
    exp_q.delete();

    // 6b: clr in a blanking cycle clears underflow
    push_beat(8'h11, 1'b1, 1'b0);
    exp_q.push_back(8'h11);
    for (int i = 0; i < 31; i++) exp_q.push_back(8'h00);
    run_frames(1, 10, 1'b0, "t6_clr");

    // 6c: clr coincident with an underflow leaves it set
    push_beat(8'h22, 1'b1, 1'b0);
    exp_q.push_back(8'h22);
    for (int i = 0; i < 31; i++) exp_q.push_back(8'h00);
    run_frames(1, 20, 1'b1, "t6_coinc");
    chk("t6_uf_end", 32'(uf), 32'd1);
    chk("t6_fe_end", 32'(fe), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
